pc_sequencer: RTL

- Consumer end of the branch-target path. It holds the architectural PC and supplies pcnext (PC+4) to branch_addressor.
- It accepts the computed branch/jump target back and applies it after exactly one MIPS branch-delay-slot instruction.
- It stalls on memory waitrequest, detects the halt-by-jump-to-zero condition, and flags misaligned targets.
- Sits between the decode/branch logic and the instruction-fetch address port.

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Holds the architectural PC, supplies pc+4 to the branch addressor and
//   applies a taken branch/jump target after exactly one delay-slot
//   instruction. Stalls on memory waitrequest, halts when a taken target
//   equal to HALT_ADDR retires its delay slot, and flags misaligned targets.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (wins over everything)
//   stall        hold all state this cycle
//   branch_taken current instruction is a taken branch/jump
//   branch_addr  branch/jump target, valid with branch_taken
//   pc           address of the current instruction
//   pcnext       pc + 4 (combinational, wraps)
//   delay_slot   current instruction is a delay-slot instruction
//   active       1 while running, 0 once halted
//   addr_error   sticky misaligned-target flag
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] pc,
    output logic [31:0] pcnext,
    output logic        delay_slot,
    output logic        active,
    output logic        addr_error
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DELAY  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] target_q;
    logic        delay_slot_q;
    logic        active_q;
    logic        addr_error_q;

    logic [31:0] pc_inc_d;
    logic        advance_d;

    assign pc_inc_d  = pc_q + 32'd4;
    // HALTED is a dead end until reset, so it never advances.
    assign advance_d = !stall && (state_q != S_HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_VECTOR;
            target_q     <= 32'd0;
            delay_slot_q <= 1'b0;
            active_q     <= 1'b1;
            addr_error_q <= 1'b0;
        end else if (advance_d) begin
            case (state_q)
                S_RUN: begin
                    if (branch_taken) begin
                        if (branch_addr[1:0] != 2'b00) begin
                            // Misaligned target: stop with pc pointing at the
                            // offending branch.
                            addr_error_q <= 1'b1;
                            active_q     <= 1'b0;
                            state_q      <= S_HALTED;
                        end else begin
                            target_q     <= branch_addr;
                            pc_q         <= pc_inc_d;
                            delay_slot_q <= 1'b1;
                            state_q      <= S_DELAY;
                        end
                    end else begin
                        pc_q <= pc_inc_d;
                    end
                end
                S_DELAY: begin
                    // A branch sitting in the delay slot is ignored; the
                    // first target always wins.
                    delay_slot_q <= 1'b0;
                    pc_q         <= target_q;
                    if (target_q == HALT_ADDR) begin
                        active_q <= 1'b0;
                        state_q  <= S_HALTED;
                    end else begin
                        state_q  <= S_RUN;
                    end
                end
                default: state_q <= S_HALTED;
            endcase
        end
    end

    assign pc         = pc_q;
    assign pcnext     = pc_inc_d;
    assign delay_slot = delay_slot_q;
    assign active     = active_q;
    assign addr_error = addr_error_q;

endmodule
